// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared constants and types for the four-floor elevator scheduler.
//   NUM_FLOORS        : number of floors served
//   FLOOR_0..FLOOR_3  : one-hot floor codes
//   sched_state_t     : scheduler FSM state encoding (IDLE, MOVE, DOOR)
//   dir_t             : travel direction (none, up, down)
//   floor_index()     : one-hot floor code -> binary floor number
//   floor_onehot()    : binary floor number -> one-hot floor code
// ---------------------------------------------------------------------------
package elevator_pkg;

   localparam int NUM_FLOORS = 4;

   localparam logic [NUM_FLOORS-1:0] FLOOR_0 = 4'b0001;
   localparam logic [NUM_FLOORS-1:0] FLOOR_1 = 4'b0010;
   localparam logic [NUM_FLOORS-1:0] FLOOR_2 = 4'b0100;
   localparam logic [NUM_FLOORS-1:0] FLOOR_3 = 4'b1000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MOVE = 2'd1,
      S_DOOR = 2'd2
   } sched_state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DOWN = 2'd2
   } dir_t;

   // Only meaningful for a one-hot input; the caller guards against others.
   function automatic logic [1:0] floor_index(input logic [NUM_FLOORS-1:0] onehot);
      floor_index = 2'd0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (onehot[i]) begin
            floor_index = 2'(i);
         end
      end
   endfunction

   function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [1:0] idx);
      case (idx)
         2'd0:    floor_onehot = FLOOR_0;
         2'd1:    floor_onehot = FLOOR_1;
         2'd2:    floor_onehot = FLOOR_2;
         default: floor_onehot = FLOOR_3;
      endcase
   endfunction

endpackage

// File: rtl/elevator_target_sel.sv
// ---------------------------------------------------------------------------
// elevator_target_sel
// Combinational SCAN / nearest-floor selector.
//   pending       in  [3:0] outstanding calls
//   present_floor in  [3:0] one-hot current floor
//   direction     in  dir_t current travel heading (DIR_NONE when idle)
//   next_target   out [3:0] one-hot floor to travel to next
//   next_dir      out dir_t direction of travel toward next_target
//   valid         out       a pending floor other than the present one exists
// With a heading, the nearest floor ahead wins, otherwise the nearest behind
// (reversal). With no heading, the nearest floor in either direction wins and
// a distance tie goes to the lower floor.
// ---------------------------------------------------------------------------
module elevator_target_sel
   import elevator_pkg::*;
(
   input  logic [NUM_FLOORS-1:0] pending,
   input  logic [NUM_FLOORS-1:0] present_floor,
   input  dir_t                  direction,
   output logic [NUM_FLOORS-1:0] next_target,
   output dir_t                  next_dir,
   output logic                  valid
);

   logic [1:0]            cur_idx;
   logic [NUM_FLOORS-1:0] cand;
   logic                  has_up;
   logic                  has_dn;
   logic [1:0]            up_idx;
   logic [1:0]            dn_idx;
   logic                  pick_up;

   // The present floor is never a travel target, so it is masked out first.
   // The upward scan runs high-to-low so the last hit is the nearest floor
   // above; the downward scan runs low-to-high for the nearest floor below.
   always_comb begin
      cur_idx = floor_index(present_floor);
      cand    = pending & ~present_floor;
      has_up  = 1'b0;
      has_dn  = 1'b0;
      up_idx  = 2'd0;
      dn_idx  = 2'd0;
      for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
         if (cand[f] && (f > int'(cur_idx))) begin
            has_up = 1'b1;
            up_idx = 2'(f);
         end
      end
      for (int f = 0; f < NUM_FLOORS; f++) begin
         if (cand[f] && (f < int'(cur_idx))) begin
            has_dn = 1'b1;
            dn_idx = 2'(f);
         end
      end

      // Upward only when strictly closer above, so ties go to the lower floor.
      case (direction)
         DIR_UP:   pick_up = has_up;
         DIR_DOWN: pick_up = has_up && !has_dn;
         default:  pick_up = has_up && (!has_dn || ((up_idx - cur_idx) < (cur_idx - dn_idx)));
      endcase

      valid = has_up || has_dn;
      if (!valid) begin
         next_target = present_floor;
         next_dir    = DIR_NONE;
      end else if (pick_up) begin
         next_target = floor_onehot(up_idx);
         next_dir    = DIR_UP;
      end else begin
         next_target = floor_onehot(dn_idx);
         next_dir    = DIR_DOWN;
      end
   end

endmodule

// File: rtl/elevator_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_scheduler
// Four-floor elevator call scheduler (IDLE / MOVE / DOOR) with SCAN ordering.
//   clk            in        system clock, rising edge
//   reset          in        synchronous active-high reset
//   call_req       in  [3:0] floor call pulses, bit i = floor i
//   tick           in        one-second strobe, counts door time only
//   present_floor  in  [3:0] one-hot floor from the floor controller
//   target_floor   out [3:0] one-hot floor to drive toward (registered)
//   door_open      out       door open indicator (registered)
//   dir_up/dir_down out      travel direction, never both high
//   pending        out [3:0] latched outstanding calls
//   fault          out       sticky: present_floor was seen not one-hot
// ---------------------------------------------------------------------------
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int DOOR_TICKS = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic                  tick,
   input  logic [NUM_FLOORS-1:0] present_floor,
   output logic [NUM_FLOORS-1:0] target_floor,
   output logic                  door_open,
   output logic                  dir_up,
   output logic                  dir_down,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  fault
);

   localparam logic [3:0] DOOR_LOAD = 4'(DOOR_TICKS);

   sched_state_t          state_q, state_d;
   logic [NUM_FLOORS-1:0] pending_q, pending_d;
   logic [NUM_FLOORS-1:0] target_q, target_d;
   logic                  door_open_q, door_open_d;
   logic                  dir_up_q, dir_up_d;
   logic                  dir_down_q, dir_down_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  fault_q, fault_d;
   // Heading is remembered through DOOR so SCAN can keep going the same way,
   // while dir_up/dir_down drop to zero whenever target equals present.
   dir_t                  heading_q, heading_d;

   logic                  present_ok;
   logic [NUM_FLOORS-1:0] call_eff;
   logic                  enter_door;
   logic [NUM_FLOORS-1:0] sel_target;
   dir_t                  sel_dir;
   logic                  sel_valid;

   assign present_ok = $onehot(present_floor);

   elevator_target_sel u_target_sel (
      .pending       (pending_q),
      .present_floor (present_floor),
      .direction     (heading_q),
      .next_target   (sel_target),
      .next_dir      (sel_dir),
      .valid         (sel_valid)
   );

   // Next-state logic. A bad present_floor freezes everything except fault.
   // Calls for the present floor are dropped while the door is open, and the
   // DOOR-entry clear is applied after the call merge so it wins a collision.
   // In IDLE a call for the present floor opens the door directly without
   // ever showing up in pending.
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      target_d    = target_q;
      door_open_d = door_open_q;
      dir_up_d    = dir_up_q;
      dir_down_d  = dir_down_q;
      cnt_d       = cnt_q;
      fault_d     = fault_q;
      heading_d   = heading_q;
      call_eff    = call_req;
      enter_door  = 1'b0;

      if (!present_ok) begin
         fault_d = 1'b1;
      end else begin
         if (state_q == S_DOOR) begin
            call_eff = call_req & ~present_floor;
         end
         pending_d = pending_q | call_eff;

         case (state_q)
            S_IDLE: begin
               if (((pending_q | call_req) & present_floor) != '0) begin
                  enter_door = 1'b1;
               end else if (sel_valid) begin
                  state_d    = S_MOVE;
                  target_d   = sel_target;
                  dir_up_d   = (sel_dir == DIR_UP);
                  dir_down_d = (sel_dir == DIR_DOWN);
                  heading_d  = sel_dir;
               end else begin
                  target_d   = present_floor;
                  dir_up_d   = 1'b0;
                  dir_down_d = 1'b0;
               end
            end

            // One-hot codes order the same way as floor numbers, so a plain
            // magnitude compare tells whether the new pick is short of target.
            S_MOVE: begin
               if (present_floor == target_q) begin
                  enter_door = 1'b1;
               end else if (sel_valid && (sel_dir == heading_q) &&
                            (((heading_q == DIR_UP)   && (sel_target < target_q)) ||
                             ((heading_q == DIR_DOWN) && (sel_target > target_q)))) begin
                  target_d = sel_target;
               end
            end

            S_DOOR: begin
               if (tick) begin
                  if (cnt_q <= 4'd1) begin
                     cnt_d       = 4'd0;
                     door_open_d = 1'b0;
                     if (sel_valid) begin
                        state_d    = S_MOVE;
                        target_d   = sel_target;
                        dir_up_d   = (sel_dir == DIR_UP);
                        dir_down_d = (sel_dir == DIR_DOWN);
                        heading_d  = sel_dir;
                     end else begin
                        state_d    = S_IDLE;
                        target_d   = present_floor;
                        dir_up_d   = 1'b0;
                        dir_down_d = 1'b0;
                        heading_d  = DIR_NONE;
                     end
                  end else begin
                     cnt_d = cnt_q - 4'd1;
                  end
               end
            end

            default: begin
               state_d = S_IDLE;
            end
         endcase

         if (enter_door) begin
            state_d     = S_DOOR;
            door_open_d = 1'b1;
            cnt_d       = DOOR_LOAD;
            pending_d   = pending_d & ~present_floor;
            target_d    = present_floor;
            dir_up_d    = 1'b0;
            dir_down_d  = 1'b0;
         end
      end
   end

   // State and output registers with synchronous reset; calls sampled while
   // reset is high are simply not latched.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pending_q   <= '0;
         target_q    <= FLOOR_0;
         door_open_q <= 1'b0;
         dir_up_q    <= 1'b0;
         dir_down_q  <= 1'b0;
         cnt_q       <= 4'd0;
         fault_q     <= 1'b0;
         heading_q   <= DIR_NONE;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         target_q    <= target_d;
         door_open_q <= door_open_d;
         dir_up_q    <= dir_up_d;
         dir_down_q  <= dir_down_d;
         cnt_q       <= cnt_d;
         fault_q     <= fault_d;
         heading_q   <= heading_d;
      end
   end

   assign target_floor = target_q;
   assign door_open    = door_open_q;
   assign dir_up       = dir_up_q;
   assign dir_down     = dir_down_q;
   assign pending      = pending_q;
   assign fault        = fault_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// ---------------------------------------------------------------------------
// tb_elevator_scheduler
// Directed self-checking bench for elevator_scheduler. Each step pushes the
// hand-derived expected output snapshot onto a scoreboard queue, drives one
// clock of stimulus, then pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_elevator_scheduler;

   localparam int DOOR_TICKS = 3;

   logic       clk;
   logic       reset;
   logic [3:0] call_req;
   logic       tick;
   logic [3:0] present_floor;
   logic [3:0] target_floor;
   logic       door_open;
   logic       dir_up;
   logic       dir_down;
   logic [3:0] pending;
   logic       fault;

   typedef struct packed {
      logic [3:0] tgt;
      logic       door;
      logic       up;
      logic       dn;
      logic [3:0] pend;
      logic       flt;
   } snap_t;

   typedef struct {
      string tag;
      snap_t v;
   } exp_t;

   exp_t sb[$];
   int   compared;
   int   mismatched;

   elevator_scheduler #(
      .DOOR_TICKS (DOOR_TICKS)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .call_req      (call_req),
      .tick          (tick),
      .present_floor (present_floor),
      .target_floor  (target_floor),
      .door_open     (door_open),
      .dir_up        (dir_up),
      .dir_down      (dir_down),
      .pending       (pending),
      .fault         (fault)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard against a stuck run: report and stop hard.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic snap_t mk(input logic [3:0] tgt, input logic door,
                                input logic up, input logic dn,
                                input logic [3:0] pend, input logic flt);
      snap_t s;
      s.tgt  = tgt;
      s.door = door;
      s.up   = up;
      s.dn   = dn;
      s.pend = pend;
      s.flt  = flt;
      return s;
   endfunction

   // Pop the oldest expectation and compare it with what the DUT shows now.
   task automatic checkOutput();
      exp_t  item;
      snap_t obs;
      item = sb.pop_front();
      obs  = mk(target_floor, door_open, dir_up, dir_down, pending, fault);
      compared++;
      assert (obs === item.v) else begin
         mismatched++;
         $error("[TB] FAIL %s observed tgt=%b door=%b up=%b dn=%b pend=%b flt=%b expected tgt=%b door=%b up=%b dn=%b pend=%b flt=%b",
                item.tag, obs.tgt, obs.door, obs.up, obs.dn, obs.pend, obs.flt,
                item.v.tgt, item.v.door, item.v.up, item.v.dn, item.v.pend, item.v.flt);
      end
   endtask

   // Queue the expectation, drive one cycle of inputs, sample 1 unit after
   // the rising edge and check.
   task automatic applyStimulus(input string tag, input logic rst,
                                input logic [3:0] call, input logic tk,
                                input logic [3:0] pres, input snap_t e);
      exp_t item;
      item.tag = tag;
      item.v   = e;
      sb.push_back(item);
      reset         = rst;
      call_req      = call;
      tick          = tk;
      present_floor = pres;
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   // Directed scenario sequence.
   initial begin
      compared      = 0;
      mismatched    = 0;
      reset         = 1'b1;
      call_req      = 4'b0000;
      tick          = 1'b0;
      present_floor = 4'b0001;

      // Reset state, with a call during reset that must be discarded.
      applyStimulus("reset1",      1, 4'b0100, 0, 4'b0001, mk(4'b0001, 0, 0, 0, 4'b0000, 0));
      applyStimulus("reset2",      1, 4'b0100, 0, 4'b0001, mk(4'b0001, 0, 0, 0, 4'b0000, 0));

      // Call to floor 2 from floor 0, travel, door for exactly DOOR_TICKS
      // ticks, present-floor call absorbed while open.
      applyStimulus("latch",       0, 4'b0100, 0, 4'b0001, mk(4'b0001, 0, 0, 0, 4'b0100, 0));
      applyStimulus("move_up",     0, 4'b0000, 0, 4'b0001, mk(4'b0100, 0, 1, 0, 4'b0100, 0));
      applyStimulus("travel",      0, 4'b0000, 0, 4'b0010, mk(4'b0100, 0, 1, 0, 4'b0100, 0));
      applyStimulus("arrive",      0, 4'b0000, 0, 4'b0100, mk(4'b0100, 1, 0, 0, 4'b0000, 0));
      applyStimulus("tick1",       0, 4'b0000, 1, 4'b0100, mk(4'b0100, 1, 0, 0, 4'b0000, 0));
      applyStimulus("absorb",      0, 4'b0100, 0, 4'b0100, mk(4'b0100, 1, 0, 0, 4'b0000, 0));
      applyStimulus("tick2",       0, 4'b0000, 1, 4'b0100, mk(4'b0100, 1, 0, 0, 4'b0000, 0));
      applyStimulus("door_close",  0, 4'b0000, 1, 4'b0100, mk(4'b0100, 0, 0, 0, 4'b0000, 0));

      // Long trip up retargeted by an intermediate call, then resumes up.
      applyStimulus("reset3",      1, 4'b0000, 0, 4'b0001, mk(4'b0001, 0, 0, 0, 4'b0000, 0));
      applyStimulus("latch_far",   0, 4'b1000, 0, 4'b0001, mk(4'b0001, 0, 0, 0, 4'b1000, 0));
      applyStimulus("move_far",    0, 4'b0000, 0, 4'b0001, mk(4'b1000, 0, 1, 0, 4'b1000, 0));
      applyStimulus("call_f1",     0, 4'b0010, 0, 4'b0001, mk(4'b1000, 0, 1, 0, 4'b1010, 0));
      applyStimulus("retarget",    0, 4'b0000, 0, 4'b0001, mk(4'b0010, 0, 1, 0, 4'b1010, 0));
      applyStimulus("door_f1",     0, 4'b0000, 0, 4'b0010, mk(4'b0010, 1, 0, 0, 4'b1000, 0));
      for (int i = 0; i < DOOR_TICKS - 1; i++) begin
         applyStimulus("door_f1_hold", 0, 4'b0000, 1, 4'b0010, mk(4'b0010, 1, 0, 0, 4'b1000, 0));
      end
      applyStimulus("resume_up",   0, 4'b0000, 1, 4'b0010, mk(4'b1000, 0, 1, 0, 4'b1000, 0));

      // Going up at floor 2 with a call behind: top floor first, then reverse.
      applyStimulus("behind_kept", 0, 4'b0001, 0, 4'b0100, mk(4'b1000, 0, 1, 0, 4'b1001, 0));
      applyStimulus("door_f3",     0, 4'b0000, 0, 4'b1000, mk(4'b1000, 1, 0, 0, 4'b0001, 0));
      for (int i = 0; i < DOOR_TICKS - 1; i++) begin
         applyStimulus("door_f3_hold", 0, 4'b0000, 1, 4'b1000, mk(4'b1000, 1, 0, 0, 4'b0001, 0));
      end
      applyStimulus("reverse_down", 0, 4'b0000, 1, 4'b1000, mk(4'b0001, 0, 0, 1, 4'b0001, 0));

      // Non-one-hot present floor mid-MOVE: freeze plus sticky fault.
      applyStimulus("fault_set",   0, 4'b0100, 1, 4'b0110, mk(4'b0001, 0, 0, 1, 4'b0001, 1));
      applyStimulus("fault_hold",  0, 4'b0000, 1, 4'b0110, mk(4'b0001, 0, 0, 1, 4'b0001, 1));
      applyStimulus("fault_reset", 1, 4'b0000, 0, 4'b0001, mk(4'b0001, 0, 0, 0, 4'b0000, 0));

      // Idle at floor 1, call at the same floor opens the door directly.
      applyStimulus("idle_track",  0, 4'b0000, 0, 4'b0010, mk(4'b0010, 0, 0, 0, 4'b0000, 0));
      applyStimulus("idle_door",   0, 4'b0010, 0, 4'b0010, mk(4'b0010, 1, 0, 0, 4'b0000, 0));
      for (int i = 0; i < DOOR_TICKS - 1; i++) begin
         applyStimulus("idle_hold", 0, 4'b0000, 1, 4'b0010, mk(4'b0010, 1, 0, 0, 4'b0000, 0));
      end
      applyStimulus("idle_close",  0, 4'b0000, 1, 4'b0010, mk(4'b0010, 0, 0, 0, 4'b0000, 0));

      // Reset while the door is open with other calls pending.
      applyStimulus("door_pend",   0, 4'b1110, 0, 4'b0010, mk(4'b0010, 1, 0, 0, 4'b1100, 0));
      applyStimulus("reset_door",  1, 4'b1000, 0, 4'b0010, mk(4'b0001, 0, 0, 0, 4'b0000, 0));
      applyStimulus("post_reset",  0, 4'b0000, 0, 4'b0010, mk(4'b0010, 0, 0, 0, 4'b0000, 0));

      // Equidistant calls from idle: lower floor wins.
      applyStimulus("tie_latch",   0, 4'b0101, 0, 4'b0010, mk(4'b0010, 0, 0, 0, 4'b0101, 0));
      applyStimulus("tie_lower",   0, 4'b0000, 0, 4'b0010, mk(4'b0001, 0, 0, 1, 4'b0101, 0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
